// File: rtl/cam_link_if.sv
// Camera-link sequencer handshake bundle.
//   master : supervisor side driving enable, loader status and the CSI frame level
//   slave  : cam_link_seq, returning sensor/loader/receiver controls and status
//   enable       level, 1 = bring up link
//   cfg_done     1-cycle pulse, I2C loader finished
//   cfg_err      1-cycle pulse, I2C NACK/abort
//   csi_in_frame asynchronous frame-active level (csi_byte_clk domain)
//   cam_en, i2c_areset_n, cfg_start, csi_reset, video_ok, fault : control/status
//   state[2:0], retry_cnt[1:0], frame_cnt[15:0]                  : observability
interface cam_link_if;
  logic        enable;
  logic        cfg_done;
  logic        cfg_err;
  logic        csi_in_frame;
  logic        cam_en;
  logic        i2c_areset_n;
  logic        cfg_start;
  logic        csi_reset;
  logic        video_ok;
  logic        fault;
  logic [2:0]  state;
  logic [1:0]  retry_cnt;
  logic [15:0] frame_cnt;

  modport master (
    output enable, cfg_done, cfg_err, csi_in_frame,
    input  cam_en, i2c_areset_n, cfg_start, csi_reset, video_ok, fault,
           state, retry_cnt, frame_cnt
  );

  modport slave (
    input  enable, cfg_done, cfg_err, csi_in_frame,
    output cam_en, i2c_areset_n, cfg_start, csi_reset, video_ok, fault,
           state, retry_cnt, frame_cnt
  );
endinterface

// File: rtl/cam_link_seq.sv
// Camera-link bring-up and supervision sequencer (clk_100 domain).
// Powers the sensor, releases/triggers the I2C loader, holds the CSI receiver
// in reset until configuration completes, then supervises frame starts and
// power-cycles the sensor with bounded retries on config failure or stall.
// Ports:
//   clk      system clock
//   reset_n  synchronous reset, active low
//   lnk      cam_link_if.slave bundle (inputs: enable, cfg_done, cfg_err,
//            csi_in_frame; outputs: enables/resets, status, counters)
// All outputs are registered and decoded from the next state, so they change
// on the same edge as state.
module cam_link_seq #(
  parameter int TICK_CYCLES = 100000,
  parameter int PWR_MS      = 20,
  parameter int CFG_MS      = 200,
  parameter int FRAME_MS    = 500,
  parameter int STALL_MS    = 200,
  parameter int OFF_MS      = 50,
  parameter int MAX_RETRY   = 3
) (
  input  logic     clk,
  input  logic     reset_n,
  cam_link_if.slave lnk
);

  localparam int PSC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PWR      = 3'd1,
    S_CFG      = 3'd2,
    S_WAIT_FRM = 3'd3,
    S_STREAM   = 3'd4,
    S_RECOVER  = 3'd5,
    S_FAULT    = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [PSC_W-1:0]   psc_q, psc_d;
  logic [15:0]        ms_q, ms_d;
  logic [1:0]         retry_q, retry_d;
  logic [15:0]        frame_q, frame_d;
  logic [1:0]         sync_q, sync_d;
  logic               prev_q, prev_d;
  logic               fstart_q, fstart_d;
  logic               cam_en_q, cam_en_d;
  logic               i2c_q, i2c_d;
  logic               cfg_start_q, cfg_start_d;
  logic               csi_reset_q, csi_reset_d;
  logic               video_ok_q, video_ok_d;
  logic               fault_q, fault_d;

  logic               tick;
  logic [15:0]        ms_nxt;
  logic               fail;
  logic               restart;

  always_comb begin
    tick    = (psc_q == PSC_W'(TICK_CYCLES - 1));
    // Compare against the value ms_cnt takes after this edge so that an
    // N-ms wait leaves the state exactly N*TICK_CYCLES cycles after entry.
    ms_nxt  = ms_q + {15'd0, tick};
    state_d = state_q;
    retry_d = retry_q;
    frame_d = frame_q;
    fail    = 1'b0;
    restart = 1'b0;

    // Synchronizer plus registered rising-edge detector on the frame level.
    sync_d   = {sync_q[0], lnk.csi_in_frame};
    prev_d   = sync_q[1];
    fstart_d = sync_q[1] & ~prev_q;

    unique case (state_q)
      S_OFF:      if (lnk.enable) state_d = S_PWR;
      S_PWR:      if (ms_nxt == 16'(PWR_MS)) state_d = S_CFG;
      S_CFG: begin
        if (lnk.cfg_done) state_d = S_WAIT_FRM;
        else if (lnk.cfg_err || ms_nxt == 16'(CFG_MS)) fail = 1'b1;
      end
      S_WAIT_FRM: begin
        if (fstart_q) state_d = S_STREAM;
        else if (ms_nxt == 16'(FRAME_MS)) fail = 1'b1;
      end
      S_STREAM: begin
        if (fstart_q) begin
          frame_d = frame_q + 16'd1;
          restart = 1'b1;
        end else if (ms_nxt == 16'(STALL_MS)) fail = 1'b1;
      end
      S_RECOVER:  if (ms_nxt == 16'(OFF_MS)) state_d = S_PWR;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_OFF;
    endcase

    if (fail) begin
      if (retry_q == 2'(MAX_RETRY)) state_d = S_FAULT;
      else begin
        state_d = S_RECOVER;
        retry_d = retry_q + 2'd1;
      end
    end

    if (!lnk.enable) state_d = S_OFF;

    if (state_d == S_STREAM && state_q != S_STREAM) retry_d = '0;
    if (state_d == S_OFF) begin
      retry_d = '0;
      frame_d = '0;
    end

    // Timebase restarts on every state change and on each streaming frame.
    if (state_d != state_q || restart) begin
      psc_d = '0;
      ms_d  = '0;
    end else begin
      psc_d = tick ? '0 : psc_q + PSC_W'(1);
      ms_d  = ms_nxt;
    end

    cam_en_d    = (state_d == S_PWR) || (state_d == S_CFG) ||
                  (state_d == S_WAIT_FRM) || (state_d == S_STREAM);
    i2c_d       = (state_d == S_CFG) || (state_d == S_WAIT_FRM) ||
                  (state_d == S_STREAM);
    csi_reset_d = !((state_d == S_WAIT_FRM) || (state_d == S_STREAM));
    video_ok_d  = (state_d == S_STREAM);
    fault_d     = (state_d == S_FAULT);
    cfg_start_d = (state_d == S_CFG) && (state_q != S_CFG);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_OFF;
      psc_q       <= '0;
      ms_q        <= '0;
      retry_q     <= '0;
      frame_q     <= '0;
      sync_q      <= '0;
      prev_q      <= 1'b0;
      fstart_q    <= 1'b0;
      cam_en_q    <= 1'b0;
      i2c_q       <= 1'b0;
      cfg_start_q <= 1'b0;
      csi_reset_q <= 1'b1;
      video_ok_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      psc_q       <= psc_d;
      ms_q        <= ms_d;
      retry_q     <= retry_d;
      frame_q     <= frame_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      fstart_q    <= fstart_d;
      cam_en_q    <= cam_en_d;
      i2c_q       <= i2c_d;
      cfg_start_q <= cfg_start_d;
      csi_reset_q <= csi_reset_d;
      video_ok_q  <= video_ok_d;
      fault_q     <= fault_d;
    end
  end

  assign lnk.state        = state_q;
  assign lnk.cam_en       = cam_en_q;
  assign lnk.i2c_areset_n = i2c_q;
  assign lnk.cfg_start    = cfg_start_q;
  assign lnk.csi_reset    = csi_reset_q;
  assign lnk.video_ok     = video_ok_q;
  assign lnk.fault        = fault_q;
  assign lnk.retry_cnt    = retry_q;
  assign lnk.frame_cnt    = frame_q;

endmodule
